meas_frame_packer: RTL and testbench

//  Downstream of the ring-oscillator measurement top level: captures one

---
 rtl/meas_frame_packer.sv | 142 ++++++++++++++
 tb/tb_meas_frame_packer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/meas_frame_packer.sv
// Measurement frame packer: captures one measurement set on the in_valid/in_ready
// handshake and serialises it as a 14-byte frame with a trailing checksum.
// The byte stream uses a valid/ready handshake for a byte-wide UART transmitter.
module meas_frame_packer #(
  parameter logic [7:0] SYNC_BYTE = 8'hA5,
  parameter int         CNT_W     = 32,
  parameter int         TEMP_W    = 20
) (
  input  logic              ref_clk,
  input  logic              rstn,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CNT_W-1:0]  cnt_2v5,
  input  logic [CNT_W-1:0]  cnt_3v6,
  input  logic [TEMP_W-1:0] temp,
  input  logic              halt_flag,
  output logic [7:0]        tx_byte,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic              frame_done,
  output logic [7:0]        drop_cnt
);

  localparam logic [3:0] LAST_IDX = 4'd13;

  typedef enum logic {IDLE, SEND} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        idx_reg, idx_next;
  logic [5:0]        seq_reg;
  logic              ovr_pending_reg;
  logic [7:0]        drop_cnt_reg;
  logic              frame_done_reg;
  logic [13:0][7:0]  frame_reg;

  logic [12:0][7:0]  hdr_bytes;
  logic [7:0]        chk_next;
  logic [23:0]       temp_ext;
  logic              accept, last_xfer, drop;

  // Candidate frame bytes built straight from the inputs; latched on accept
  assign temp_ext     = 24'(temp);
  assign hdr_bytes[0] = SYNC_BYTE;
  assign hdr_bytes[1] = {halt_flag, ovr_pending_reg, seq_reg};

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cnt_bytes
      assign hdr_bytes[2 + gi] = cnt_2v5[CNT_W-1-8*gi -: 8];
      assign hdr_bytes[6 + gi] = cnt_3v6[CNT_W-1-8*gi -: 8];
    end
    for (genvar gi = 0; gi < 3; gi++) begin : g_temp_bytes
      assign hdr_bytes[10 + gi] = temp_ext[23-8*gi -: 8];
    end
  endgenerate

  // Checksum precomputed at accept so the whole frame sums to zero mod 256
  always_comb begin
    logic [7:0] sum_acc;
    sum_acc = 8'h00;
    for (int i = 0; i < 13; i++) begin
      sum_acc = sum_acc + hdr_bytes[i];
    end
    chk_next = 8'h00 - sum_acc;
  end

  assign in_ready   = (state_reg == IDLE);
  assign tx_valid   = (state_reg == SEND);
  assign tx_byte    = tx_valid ? frame_reg[idx_reg] : 8'h00;
  assign frame_done = frame_done_reg;
  assign drop_cnt   = drop_cnt_reg;
  assign drop       = in_valid & ~in_ready;

  // Next-state logic: accept in IDLE, walk the byte index on each transfer
  always_comb begin
    state_next = state_reg;
    idx_next   = idx_reg;
    accept     = 1'b0;
    last_xfer  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (in_valid) begin
          accept     = 1'b1;
          state_next = SEND;
          idx_next   = 4'd0;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx_reg == LAST_IDX) begin
            last_xfer  = 1'b1;
            state_next = IDLE;
            idx_next   = 4'd0;
          end else begin
            idx_next = idx_reg + 4'd1;
          end
        end
      end
      default: begin
        state_next = IDLE;
        idx_next   = 4'd0;
      end
    endcase
  end

  // Control state, sequence number and overrun bookkeeping
  always_ff @(posedge ref_clk) begin
    if (!rstn) begin
      state_reg       <= IDLE;
      idx_reg         <= 4'd0;
      seq_reg         <= 6'd0;
      ovr_pending_reg <= 1'b0;
      drop_cnt_reg    <= 8'd0;
      frame_done_reg  <= 1'b0;
    end else begin
      state_reg      <= state_next;
      idx_reg        <= idx_next;
      frame_done_reg <= last_xfer;
      if (last_xfer) begin
        seq_reg <= seq_reg + 6'd1;
      end
      if (accept) begin
        ovr_pending_reg <= 1'b0;
      end else if (drop) begin
        ovr_pending_reg <= 1'b1;
      end
      if (drop && (drop_cnt_reg != 8'hFF)) begin
        drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
    end
  end

  // Frame buffer; contents only matter while in SEND, so no reset is needed
  always_ff @(posedge ref_clk) begin
    if (accept) begin
      for (int i = 0; i < 13; i++) begin
        frame_reg[i] <= hdr_bytes[i];
      end
      frame_reg[13] <= chk_next;
    end
  end

endmodule

// File: tb/tb_meas_frame_packer.sv
// Self-checking bench for meas_frame_packer: table of hand-computed frames
// plus directed sequences for stalls, overrun, sequence wrap and mid-frame reset.
module tb_meas_frame_packer;

  logic        ref_clk = 1'b0;
  logic        rstn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] cnt_2v5;
  logic [31:0] cnt_3v6;
  logic [19:0] temp;
  logic        halt_flag;
  logic [7:0]  tx_byte;
  logic        tx_valid;
  logic        tx_ready;
  logic        frame_done;
  logic [7:0]  drop_cnt;

  meas_frame_packer dut (
    .ref_clk    (ref_clk),
    .rstn       (rstn),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .cnt_2v5    (cnt_2v5),
    .cnt_3v6    (cnt_3v6),
    .temp       (temp),
    .halt_flag  (halt_flag),
    .tx_byte    (tx_byte),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .frame_done (frame_done),
    .drop_cnt   (drop_cnt)
  );

  always #5 ref_clk = ~ref_clk;

  int         n_pass  = 0;
  int         n_total = 0;
  logic [7:0] rx [14];
  int         last_cycles;
  logic [5:0] seq_m;
  logic       ovr_m;

  typedef struct {
    logic [31:0] c2;
    logic [31:0] c3;
    logic [19:0] t;
    logic        halt;
    int          mode;
    logic [7:0]  exp_b1;
    logic [7:0]  exp_chk;
  } vec_t;

  vec_t vecs [4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic step();
    @(posedge ref_clk);
    #1;
  endtask

  task automatic do_reset();
    rstn     = 1'b0;
    in_valid = 1'b0;
    tx_ready = 1'b0;
    step();
    rstn  = 1'b1;
    seq_m = 6'd0;
    ovr_m = 1'b0;
  endtask

  function automatic logic [7:0] model_chk(input logic [31:0] c2, input logic [31:0] c3,
                                           input logic [19:0] t, input logic [7:0] b1);
    logic [7:0] s;
    s = 8'hA5 + b1 + c2[31:24] + c2[23:16] + c2[15:8] + c2[7:0]
        + c3[31:24] + c3[23:16] + c3[15:8] + c3[7:0]
        + {4'h0, t[19:16]} + t[15:8] + t[7:0];
    return 8'h00 - s;
  endfunction

  // Present one set while idle; byte 0 must be valid the following cycle
  task automatic start_frame(input logic [31:0] c2, input logic [31:0] c3,
                             input logic [19:0] t, input logic h);
    check("in_ready_idle", in_ready, 1'b1);
    cnt_2v5   = c2;
    cnt_3v6   = c3;
    temp      = t;
    halt_flag = h;
    in_valid  = 1'b1;
    step();
    in_valid = 1'b0;
    ovr_m    = 1'b0;
    check("first_byte_valid", tx_valid, 1'b1);
    check("frame_done_low_on_accept", frame_done, 1'b0);
  endtask

  // Drain one frame; mode 0 = always ready, mode 1 = ready one cycle in three.
  // drop_at >= 0 pulses in_valid once while that byte index is pending.
  task automatic collect(input int mode, input int drop_at);
    int         got;
    int         cyc;
    int         fd_seen;
    bit         stalled;
    bit         dropped;
    logic [7:0] held;
    got = 0; cyc = 0; fd_seen = 0; stalled = 0; dropped = 0; held = 8'h00;
    while (got < 14 && cyc < 200) begin
      tx_ready = (mode == 0) ? 1'b1 : ((cyc % 3) == 2);
      if (drop_at == got && !dropped) begin
        in_valid = 1'b1;
        dropped  = 1;
        ovr_m    = 1'b1;
      end else begin
        in_valid = 1'b0;
      end
      if (stalled) check("stall_hold", tx_byte, held);
      if (frame_done) fd_seen++;
      check("tx_valid_in_frame", tx_valid, 1'b1);
      if (tx_valid && tx_ready) begin
        rx[got] = tx_byte;
        got++;
        stalled = 0;
      end else begin
        held    = tx_byte;
        stalled = 1;
      end
      step();
      cyc++;
    end
    in_valid    = 1'b0;
    last_cycles = cyc;
    if (got < 14) check("collect_timeout", got, 14);
    check("frame_done_pulse", frame_done, 1'b1);
    check("tx_valid_after_last", tx_valid, 1'b0);
    check("in_ready_after_last", in_ready, 1'b1);
    check("frame_done_early", fd_seen, 0);
    seq_m = seq_m + 6'd1;
  endtask

  task automatic verify(input string tag, input logic [31:0] c2, input logic [31:0] c3,
                        input logic [19:0] t, input logic [7:0] b1, input logic [7:0] chk);
    logic [7:0] e [14];
    logic [7:0] s;
    e[0]  = 8'hA5;       e[1]  = b1;
    e[2]  = c2[31:24];   e[3]  = c2[23:16];  e[4]  = c2[15:8];  e[5] = c2[7:0];
    e[6]  = c3[31:24];   e[7]  = c3[23:16];  e[8]  = c3[15:8];  e[9] = c3[7:0];
    e[10] = {4'h0, t[19:16]}; e[11] = t[15:8]; e[12] = t[7:0];
    e[13] = chk;
    s = 8'h00;
    for (int i = 0; i < 14; i++) begin
      check($sformatf("%s_b%0d", tag, i), rx[i], e[i]);
      s = s + rx[i];
    end
    check({tag, "_sum0"}, s, 8'h00);
    $display("frame %s: b1=%h chk=%h cycles=%0d", tag, rx[1], rx[13], last_cycles);
  endtask

  initial begin
    logic [31:0] c2;
    logic [31:0] c3;
    logic [19:0] t;
    logic [7:0]  b1;

    rstn = 1'b0; in_valid = 1'b0; tx_ready = 1'b0; halt_flag = 1'b0;
    cnt_2v5 = '0; cnt_3v6 = '0; temp = '0;
    seq_m = 6'd0; ovr_m = 1'b0;

    vecs[0] = '{32'h01020304, 32'h0A0B0C0D, 20'h7FFFF, 1'b0, 0, 8'h00, 8'h1E};
    vecs[1] = '{32'h01020304, 32'h0A0B0C0D, 20'h7FFFF, 1'b0, 1, 8'h01, 8'h1D};
    vecs[2] = '{32'h00000000, 32'h00000000, 20'h00000, 1'b1, 0, 8'h82, 8'hD9};
    vecs[3] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 20'hFFFFF, 1'b0, 1, 8'h03, 8'h53};

    // Reset state
    do_reset();
    do_reset();
    check("rst_tx_valid", tx_valid, 1'b0);
    check("rst_tx_byte", tx_byte, 8'h00);
    check("rst_frame_done", frame_done, 1'b0);
    check("rst_drop_cnt", drop_cnt, 8'h00);
    check("rst_in_ready", in_ready, 1'b1);

    // Table-driven frames (T1 plain, T2 stalled, extreme field values)
    for (int v = 0; v < 4; v++) begin
      start_frame(vecs[v].c2, vecs[v].c3, vecs[v].t, vecs[v].halt);
      collect(vecs[v].mode, -1);
      verify($sformatf("vec%0d", v), vecs[v].c2, vecs[v].c3, vecs[v].t,
             vecs[v].exp_b1, vecs[v].exp_chk);
      if (vecs[v].mode == 0) check($sformatf("vec%0d_cycles", v), last_cycles, 14);
    end

    // T5: reset while b7 is pending (one drop first so the reset is visible)
    start_frame(32'h01020304, 32'h0A0B0C0D, 20'h7FFFF, 1'b0);
    tx_ready = 1'b1;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) step();
    check("t5_b7_pending", tx_byte, 8'h0B);
    check("t5_drop_before", drop_cnt, 8'd1);
    rstn = 1'b0;
    step();
    rstn = 1'b1; tx_ready = 1'b0; seq_m = 6'd0; ovr_m = 1'b0;
    check("t5_tx_valid", tx_valid, 1'b0);
    check("t5_tx_byte", tx_byte, 8'h00);
    check("t5_drop_cnt", drop_cnt, 8'd0);
    check("t5_in_ready", in_ready, 1'b1);

    // T3: drop while b5 pending, then ovr+halt, then ovr cleared
    start_frame(32'h01020304, 32'h0A0B0C0D, 20'h7FFFF, 1'b0);
    collect(0, 5);
    verify("t3_a", 32'h01020304, 32'h0A0B0C0D, 20'h7FFFF, 8'h00, 8'h1E);
    check("t3_drop_cnt", drop_cnt, 8'd1);
    start_frame(32'h0, 32'h0, 20'h0, 1'b1);
    collect(0, -1);
    verify("t3_b", 32'h0, 32'h0, 20'h0, 8'hC1, 8'h9A);
    start_frame(32'h0, 32'h0, 20'h0, 1'b0);
    collect(1, -1);
    verify("t3_c", 32'h0, 32'h0, 20'h0, 8'h02, 8'h59);

    // T4: 64 back-to-back frames, 65th wraps the sequence to 0
    do_reset();
    for (int f = 0; f < 65; f++) begin
      c2 = $urandom; c3 = $urandom; t = 20'($urandom);
      b1 = {1'b0, ovr_m, seq_m};
      if (f == 64) check("t4_seq_model_wrapped", {26'd0, seq_m}, 32'd0);
      start_frame(c2, c3, t, 1'b0);
      collect(0, -1);
      verify($sformatf("t4_f%0d", f), c2, c3, t, (f == 64) ? 8'h00 : b1,
             model_chk(c2, c3, t, b1));
    end

    // T6: 300 drops in one frame saturate drop_cnt at 255
    c2 = 32'hDEADBEEF; c3 = 32'h12345678; t = 20'hABCDE;
    b1 = {1'b0, ovr_m, seq_m};
    start_frame(c2, c3, t, 1'b0);
    in_valid = 1'b1; tx_ready = 1'b0;
    for (int i = 0; i < 300; i++) step();
    in_valid = 1'b0;
    ovr_m = 1'b1;
    check("t6_hold_byte", tx_byte, 8'hA5);
    check("t6_drop_sat", drop_cnt, 8'd255);
    collect(0, -1);
    verify("t6_a", c2, c3, t, b1, model_chk(c2, c3, t, b1));
    check("t6_drop_held", drop_cnt, 8'd255);
    b1 = {1'b0, ovr_m, seq_m};
    check("t6_ovr_expected", b1[6], 1'b1);
    start_frame(c3, c2, t, 1'b0);
    collect(0, -1);
    verify("t6_b", c3, c2, t, b1, model_chk(c3, c2, t, b1));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
